// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: processor and NIC share one single-port dmem.
// Grants are combinational from the current requests and the burst counter.
// A registered owner tag routes the one-cycle-late read data back to the
// requester that issued the read.
module dmem_arbiter #(
    parameter int PROC_BURST = 3
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        P_Req,
    input  logic        P_WrEn,
    input  logic [0:7]  P_Addr,
    input  logic [0:63] P_Wdata,
    output logic        P_Gnt,
    output logic        P_Rvalid,
    input  logic        N_Req,
    input  logic        N_WrEn,
    input  logic [0:7]  N_Addr,
    input  logic [0:63] N_Wdata,
    output logic        N_Gnt,
    output logic        N_Rvalid,
    output logic [0:63] Rdata,
    output logic        DmemEn,
    output logic        DmemWrEn,
    output logic [0:7]  Mem_Addr,
    output logic [0:63] Data_Out,
    input  logic [0:63] Data_In
);

    // A zero burst limit still needs a 1-bit counter to hold the value 0.
    localparam int CNT_W = (PROC_BURST > 0) ? $clog2(PROC_BURST + 1) : 1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(PROC_BURST);

    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_p_rd;
    logic             r_n_rd;

    logic             w_p_wins;
    logic             w_p_gnt;
    logic             w_n_gnt;

    // Arbitration: the processor wins contention until it has used its burst.
    // Grants are forced low while reset is asserted.
    always_comb begin
        w_p_wins = P_Req && (!N_Req || (r_burst_cnt != BURST_MAX));
        w_p_gnt  = Reset_n && w_p_wins;
        w_n_gnt  = Reset_n && N_Req && !w_p_wins;
    end

    assign P_Gnt = w_p_gnt;
    assign N_Gnt = w_n_gnt;

    // Memory command mux: drive the granted port's command, all zeros when idle.
    always_comb begin
        DmemEn   = 1'b0;
        DmemWrEn = 1'b0;
        Mem_Addr = '0;
        Data_Out = '0;
        if (w_p_gnt) begin
            DmemEn   = 1'b1;
            DmemWrEn = P_WrEn;
            Mem_Addr = P_Addr;
            Data_Out = P_Wdata;
        end else if (w_n_gnt) begin
            DmemEn   = 1'b1;
            DmemWrEn = N_WrEn;
            Mem_Addr = N_Addr;
            Data_Out = N_Wdata;
        end
    end

    // Burst counter: counts processor grants while the NIC waits; any cycle
    // where the NIC is served or not asking restarts the count.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_burst_cnt <= '0;
        end else if (!N_Req || w_n_gnt) begin
            r_burst_cnt <= '0;
        end else if (w_p_gnt && (r_burst_cnt != BURST_MAX)) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end
    end

    // Owner tag: remembers who issued the read so the returning data is
    // qualified for that port only; reset discards any read in flight.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_p_rd <= 1'b0;
            r_n_rd <= 1'b0;
        end else begin
            r_p_rd <= w_p_gnt && !P_WrEn;
            r_n_rd <= w_n_gnt && !N_WrEn;
        end
    end

    assign P_Rvalid = r_p_rd;
    assign N_Rvalid = r_n_rd;

    // Read return: pass dmem data through only while a read-valid is up.
    always_comb begin
        Rdata = '0;
        if (r_p_rd || r_n_rd) begin
            Rdata = Data_In;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of per-cycle vectors plus hand
// sequences for reset-during-read and long idle. A small synchronous memory
// model answers reads one cycle after the grant.
module tb_dmem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        P_Req = 1'b0, P_WrEn = 1'b0;
    logic [0:7]  P_Addr = '0;
    logic [0:63] P_Wdata = '0;
    logic        N_Req = 1'b0, N_WrEn = 1'b0;
    logic [0:7]  N_Addr = '0;
    logic [0:63] N_Wdata = '0;
    logic        P_Gnt, P_Rvalid, N_Gnt, N_Rvalid;
    logic [0:63] Rdata;
    logic        DmemEn, DmemWrEn;
    logic [0:7]  Mem_Addr;
    logic [0:63] Data_Out;
    logic [0:63] Data_In = '0;

    // Second instance with a zero burst limit, checked for grants only.
    logic        z_P_Gnt, z_P_Rvalid, z_N_Gnt, z_N_Rvalid;
    logic [0:63] z_Rdata;
    logic        z_DmemEn, z_DmemWrEn;
    logic [0:7]  z_Mem_Addr;
    logic [0:63] z_Data_Out;
    logic [0:63] z_Data_In = '0;

    logic [63:0] mem [0:255];

    int n_checks = 0;
    int n_err = 0;

    dmem_arbiter #(.PROC_BURST(3)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .P_Req(P_Req), .P_WrEn(P_WrEn), .P_Addr(P_Addr), .P_Wdata(P_Wdata),
        .P_Gnt(P_Gnt), .P_Rvalid(P_Rvalid),
        .N_Req(N_Req), .N_WrEn(N_WrEn), .N_Addr(N_Addr), .N_Wdata(N_Wdata),
        .N_Gnt(N_Gnt), .N_Rvalid(N_Rvalid),
        .Rdata(Rdata), .DmemEn(DmemEn), .DmemWrEn(DmemWrEn),
        .Mem_Addr(Mem_Addr), .Data_Out(Data_Out), .Data_In(Data_In)
    );

    dmem_arbiter #(.PROC_BURST(0)) dut0 (
        .Clock(Clock), .Reset_n(Reset_n),
        .P_Req(P_Req), .P_WrEn(P_WrEn), .P_Addr(P_Addr), .P_Wdata(P_Wdata),
        .P_Gnt(z_P_Gnt), .P_Rvalid(z_P_Rvalid),
        .N_Req(N_Req), .N_WrEn(N_WrEn), .N_Addr(N_Addr), .N_Wdata(N_Wdata),
        .N_Gnt(z_N_Gnt), .N_Rvalid(z_N_Rvalid),
        .Rdata(z_Rdata), .DmemEn(z_DmemEn), .DmemWrEn(z_DmemWrEn),
        .Mem_Addr(z_Mem_Addr), .Data_Out(z_Data_Out), .Data_In(z_Data_In)
    );

    always #5 Clock = ~Clock;

    // Synchronous memory model: write on the grant edge, read data appears
    // on Data_In for the following cycle.
    always @(posedge Clock) begin
        if (DmemEn && DmemWrEn) mem[Mem_Addr] <= Data_Out;
        if (DmemEn && !DmemWrEn) Data_In <= mem[Mem_Addr];
    end

    typedef struct {
        logic        p_req, p_wr;
        logic [7:0]  p_addr;
        logic [63:0] p_wd;
        logic        n_req, n_wr;
        logic [7:0]  n_addr;
        logic [63:0] n_wd;
        logic        e_pg, e_ng, e_en, e_we;
        logic [7:0]  e_addr;
        logic [63:0] e_dout;
        logic        e_pv, e_nv;
        logic [63:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        logic pr, logic pw, logic [7:0] pa, logic [63:0] pd,
        logic nr, logic nw, logic [7:0] na, logic [63:0] nd,
        logic pg, logic ng, logic en, logic we, logic [7:0] ea, logic [63:0] ed,
        logic pv, logic nv, logic [63:0] rd);
        vec_t t;
        t.p_req = pr; t.p_wr = pw; t.p_addr = pa; t.p_wd = pd;
        t.n_req = nr; t.n_wr = nw; t.n_addr = na; t.n_wd = nd;
        t.e_pg = pg; t.e_ng = ng; t.e_en = en; t.e_we = we;
        t.e_addr = ea; t.e_dout = ed;
        t.e_pv = pv; t.e_nv = nv; t.e_rd = rd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 64'h0;
        mem[8'h10] = 64'hA5A5_0000_0000_0001;
        mem[8'h01] = 64'h11;
        mem[8'h02] = 64'h22;
        mem[8'h03] = 64'h33;

        //          P: req wr addr   wdata              N: req wr addr   wdata        exp: pg ng en we addr  dout           pv nv rdata
        vecs.push_back(v(0,0,8'h00,64'h0,     0,0,8'h00,64'h0,     0,0,0,0,8'h00,64'h0,     0,0,64'h0));
        vecs.push_back(v(1,0,8'h10,64'h0,     0,0,8'h00,64'h0,     1,0,1,0,8'h10,64'h0,     0,0,64'h0));
        vecs.push_back(v(0,0,8'h00,64'h0,     0,0,8'h00,64'h0,     0,0,0,0,8'h00,64'h0,     1,0,64'hA5A5_0000_0000_0001));
        vecs.push_back(v(0,0,8'h00,64'h0,     1,1,8'h20,64'h1234,  0,1,1,1,8'h20,64'h1234,  0,0,64'h0));
        vecs.push_back(v(1,0,8'h20,64'h0,     0,0,8'h00,64'h0,     1,0,1,0,8'h20,64'h0,     0,0,64'h0));
        vecs.push_back(v(0,0,8'h00,64'h0,     0,0,8'h00,64'h0,     0,0,0,0,8'h00,64'h0,     1,0,64'h1234));
        vecs.push_back(v(1,0,8'h01,64'h0,     0,0,8'h00,64'h0,     1,0,1,0,8'h01,64'h0,     0,0,64'h0));
        vecs.push_back(v(0,0,8'h00,64'h0,     1,0,8'h02,64'h0,     0,1,1,0,8'h02,64'h0,     1,0,64'h11));
        vecs.push_back(v(1,0,8'h03,64'h0,     0,0,8'h00,64'h0,     1,0,1,0,8'h03,64'h0,     0,1,64'h22));
        vecs.push_back(v(0,0,8'h00,64'h0,     0,0,8'h00,64'h0,     0,0,0,0,8'h00,64'h0,     1,0,64'h33));
        // Continuous contention: P,P,P,N,P,P,P,N
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++)
                vecs.push_back(v(1,1,8'h40,64'hAA, 1,1,8'h41,64'hBB, 1,0,1,1,8'h40,64'hAA, 0,0,64'h0));
            vecs.push_back(v(1,1,8'h40,64'hAA, 1,1,8'h41,64'hBB, 0,1,1,1,8'h41,64'hBB, 0,0,64'h0));
        end
        // One P grant under contention, then NIC drops out: count restarts.
        vecs.push_back(v(1,1,8'h40,64'hAA, 1,1,8'h41,64'hBB, 1,0,1,1,8'h40,64'hAA, 0,0,64'h0));
        vecs.push_back(v(1,1,8'h40,64'hAA, 0,0,8'h00,64'h0,  1,0,1,1,8'h40,64'hAA, 0,0,64'h0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(v(1,1,8'h40,64'hAA, 1,1,8'h41,64'hBB, 1,0,1,1,8'h40,64'hAA, 0,0,64'h0));
        vecs.push_back(v(1,1,8'h40,64'hAA, 1,1,8'h41,64'hBB, 0,1,1,1,8'h41,64'hBB, 0,0,64'h0));
        vecs.push_back(v(0,0,8'h00,64'h0,     0,0,8'h00,64'h0,     0,0,0,0,8'h00,64'h0,     0,0,64'h0));

        // Reset state with requests present.
        P_Req = 1'b1; N_Req = 1'b1; P_WrEn = 1'b1;
        #2;
        chk("rst P_Gnt", 64'(P_Gnt), 64'h0);
        chk("rst N_Gnt", 64'(N_Gnt), 64'h0);
        chk("rst DmemEn", 64'(DmemEn), 64'h0);
        chk("rst DmemWrEn", 64'(DmemWrEn), 64'h0);
        chk("rst Rvalid", 64'({P_Rvalid, N_Rvalid}), 64'h0);
        chk("rst Rdata", 64'(Rdata), 64'h0);
        repeat (2) @(negedge Clock);
        P_Req = 1'b0; N_Req = 1'b0; P_WrEn = 1'b0;
        Reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clock);
            P_Req = vecs[i].p_req; P_WrEn = vecs[i].p_wr;
            P_Addr = vecs[i].p_addr; P_Wdata = vecs[i].p_wd;
            N_Req = vecs[i].n_req; N_WrEn = vecs[i].n_wr;
            N_Addr = vecs[i].n_addr; N_Wdata = vecs[i].n_wd;
            #1;
            chk($sformatf("v%0d P_Gnt", i), 64'(P_Gnt), 64'(vecs[i].e_pg));
            chk($sformatf("v%0d N_Gnt", i), 64'(N_Gnt), 64'(vecs[i].e_ng));
            chk($sformatf("v%0d DmemEn", i), 64'(DmemEn), 64'(vecs[i].e_en));
            chk($sformatf("v%0d DmemWrEn", i), 64'(DmemWrEn), 64'(vecs[i].e_we));
            chk($sformatf("v%0d Mem_Addr", i), 64'(Mem_Addr), 64'(vecs[i].e_addr));
            chk($sformatf("v%0d Data_Out", i), 64'(Data_Out), vecs[i].e_dout);
            chk($sformatf("v%0d P_Rvalid", i), 64'(P_Rvalid), 64'(vecs[i].e_pv));
            chk($sformatf("v%0d N_Rvalid", i), 64'(N_Rvalid), 64'(vecs[i].e_nv));
            chk($sformatf("v%0d Rdata", i), 64'(Rdata), vecs[i].e_rd);
            // Zero burst limit: NIC takes every contention cycle.
            chk($sformatf("v%0d b0 P_Gnt", i), 64'(z_P_Gnt), 64'(vecs[i].p_req && !vecs[i].n_req));
            chk($sformatf("v%0d b0 N_Gnt", i), 64'(z_N_Gnt), 64'(vecs[i].n_req));
        end

        // Reset right after a P read grant discards the pending read.
        @(negedge Clock);
        P_Req = 1'b1; P_WrEn = 1'b0; P_Addr = 8'h10; N_Req = 1'b0;
        #1;
        chk("rr P_Gnt", 64'(P_Gnt), 64'h1);
        @(posedge Clock);
        #1;
        Reset_n = 1'b0;
        P_Req = 1'b1; P_WrEn = 1'b1; N_Req = 1'b1; N_WrEn = 1'b1;
        #1;
        chk("rr P_Rvalid", 64'(P_Rvalid), 64'h0);
        chk("rr Rdata", 64'(Rdata), 64'h0);
        chk("rr grants", 64'({P_Gnt, N_Gnt}), 64'h0);
        chk("rr DmemEn", 64'({DmemEn, DmemWrEn}), 64'h0);
        repeat (2) begin
            @(negedge Clock);
            #1;
            chk("rr hold P_Rvalid", 64'(P_Rvalid), 64'h0);
            chk("rr hold grants", 64'({P_Gnt, N_Gnt}), 64'h0);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        P_Req = 1'b0; P_WrEn = 1'b0;
        N_Req = 1'b1; N_WrEn = 1'b0; N_Addr = 8'h02;
        #1;
        chk("post N_Gnt", 64'(N_Gnt), 64'h1);
        chk("post Mem_Addr", 64'(Mem_Addr), 64'h02);
        chk("post P_Rvalid", 64'(P_Rvalid), 64'h0);
        @(negedge Clock);
        N_Req = 1'b0; N_Addr = 8'h00;
        #1;
        chk("post N_Rvalid", 64'(N_Rvalid), 64'h1);
        chk("post P_Rvalid2", 64'(P_Rvalid), 64'h0);
        chk("post Rdata", 64'(Rdata), 64'h22);

        // Long idle: memory port quiet, read bus zero.
        for (int c = 0; c < 10; c++) begin
            @(negedge Clock);
            #1;
            chk($sformatf("idle%0d DmemEn", c), 64'(DmemEn), 64'h0);
            chk($sformatf("idle%0d Mem_Addr", c), 64'(Mem_Addr), 64'h0);
            chk($sformatf("idle%0d Data_Out", c), 64'(Data_Out), 64'h0);
            chk($sformatf("idle%0d Rdata", c), 64'(Rdata), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter PROC_BURST, default 3: max consecutive processor grants while the NIC request is pending.
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 P_Req  input  1  processor memory request, held until granted.
REQ-005 P_WrEn  input  1  processor write (1) / read (0), valid with P_Req.
REQ-006 P_Addr  input  [0:7]  processor word address.
REQ-007 P_Wdata  input  [0:63]  processor write data.
REQ-008 P_Gnt  output  1  processor request accepted this cycle.
REQ-009 P_Rvalid  output  1  processor read data valid.
REQ-010 N_Req, N_WrEn, N_Addr[0:7], N_Wdata[0:63]  input  NIC port, same meaning as P_*.
REQ-011 N_Gnt, N_Rvalid  output  1  NIC grant / read-valid, same meaning as P_*.
REQ-012 Rdata  output  [0:63]  shared read-return bus, qualified by P_Rvalid or N_Rvalid.
REQ-013 DmemEn, DmemWrEn  output  1  dmem enable / write enable.
REQ-014 Mem_Addr  output  [0:7]; Data_Out  output  [0:63]; Data_In  input  [0:63]  dmem address, write data, read data.

Function
REQ-015 Grants SHALL be combinational from current requests and registered state; at most one grant per cycle.
REQ-016 Only one requester active: that requester SHALL be granted the same cycle.
REQ-017 Both active: processor SHALL win unless burst_cnt == PROC_BURST, in which case NIC SHALL win.
REQ-018 burst_cnt (width ceil(log2(PROC_BURST+1))) SHALL increment on each P_Gnt cycle with N_Req=1, saturating at PROC_BURST.
REQ-019 burst_cnt SHALL clear on any N_Gnt cycle and on any cycle with N_Req=0.
REQ-020 Granted cycle: DmemEn=1, DmemWrEn=granted WrEn, Mem_Addr/Data_Out = granted Addr/Wdata.
REQ-021 No grant: DmemEn=0, DmemWrEn=0, Mem_Addr=0, Data_Out=0.
REQ-022 Granted read: a registered owner tag SHALL be set; the owner's Rvalid SHALL assert exactly one cycle after grant, with Rdata = Data_In that cycle.
REQ-023 Granted write: no Rvalid SHALL be generated; write commits on the grant-cycle clock edge.
REQ-024 Back-to-back reads (same or different owner) SHALL be accepted every cycle; Rvalid pulses SHALL follow grant order, one per read.
REQ-025 P_Rvalid and N_Rvalid SHALL never both be 1; Rdata SHALL be 0 when neither is 1.
REQ-026 Requester deasserting Req without grant SHALL be legal; no state change results.
REQ-027 PROC_BURST=0: NIC SHALL win every contention cycle.

Reset
REQ-028 Reset_n=0 SHALL immediately force burst_cnt=0, owner tag cleared, P_Rvalid=N_Rvalid=0, Rdata=0.
REQ-029 Read granted in the cycle before reset assertion SHALL NOT produce Rvalid after reset release.
REQ-030 During reset grants and DmemEn/DmemWrEn SHALL be 0 regardless of requests.
REQ-031 First rising edge after Reset_n deasserts SHALL arbitrate normally with burst_cnt=0.

Verification
REQ-032 P read addr 0x10 alone, MEM[0x10]=64'hA5A5_0000_0000_0001 -> P_Gnt same cycle; next cycle P_Rvalid=1, Rdata=64'hA5A5_0000_0000_0001, N_Rvalid=0.
REQ-033 P and N both requesting continuously, PROC_BURST=3 -> grant sequence P,P,P,N,P,P,P,N repeating.
REQ-034 N write addr 0x20 data 64'h1234 then P read 0x20 next cycle -> P_Rdata=64'h1234, no N_Rvalid.
REQ-035 Alternating reads P@0x01, N@0x02, P@0x03 back-to-back -> Rvalid pulses P,N,P on consecutive cycles with matching data.
REQ-036 Reset_n asserted the cycle after a P read grant -> P_Rvalid stays 0; after release, N read alone granted immediately.
REQ-037 Both idle 10 cycles -> DmemEn=0, Mem_Addr=0, Data_Out=0, burst_cnt=0 throughout.
